// File: rtl/glitch_sequencer.sv
// Clock-glitch sequencer: optional PLL relock, lock wait, trigger arm, then
// N glitch-enable windows with programmable delay, width and gap.
module glitch_sequencer #(
  parameter int CNT_W         = 16,
  parameter int RELOCK_CYCLES = 16,
  parameter int LOCK_TIMEOUT  = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic [7:0]       cfg_count,
  input  logic             cfg_relock,
  input  logic             start,
  input  logic             abort,
  input  logic             trigger,
  input  logic             pll_locked,
  output logic             pll_relock,
  output logic             glitch_en,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [7:0]       pulses_done
);

  localparam int TMAX = (LOCK_TIMEOUT > RELOCK_CYCLES) ? LOCK_TIMEOUT : RELOCK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] RELOCK_LD = TW'((RELOCK_CYCLES > 0) ? RELOCK_CYCLES - 1 : 0);
  localparam logic [TW-1:0] LOCK_LD   = TW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE, RELOCK, WAIT_LOCK, ARMED, DELAY, GLITCH, GAP, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [CNT_W-1:0] dly_q, wid_q, gap_q;
  logic [7:0]       num_q;
  logic             trig_q;
  logic             err_q, err_d;
  logic [7:0]       pulses_q, pulses_d;
  logic             ld_cfg;

  // Down-counters reload with length-1 so a zero length still lasts one cycle.
  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    err_d    = err_q;
    pulses_d = pulses_q;
    ld_cfg   = 1'b0;
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            ld_cfg   = 1'b1;
            err_d    = 1'b0;
            pulses_d = '0;
            if (cfg_count == 8'd0) begin
              state_d = DONE;
            end else if (cfg_relock) begin
              state_d = RELOCK;
              tmr_d   = RELOCK_LD;
            end else begin
              state_d = WAIT_LOCK;
              tmr_d   = LOCK_LD;
            end
          end
        end
        RELOCK: begin
          if (tmr_q == '0) begin
            state_d = WAIT_LOCK;
            tmr_d   = LOCK_LD;
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (pll_locked) begin
            state_d = ARMED;
          end else if (tmr_q == '0) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end
        ARMED, DELAY, GLITCH, GAP: begin
          if (!pll_locked) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (state_q == ARMED) begin
            if (trigger && !trig_q) begin
              if (dly_q == '0) begin
                state_d = GLITCH;
                cnt_d   = len_m1(wid_q);
              end else begin
                state_d = DELAY;
                cnt_d   = dly_q - 1'b1;
              end
            end
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (state_q == GLITCH) begin
            pulses_d = (pulses_q == 8'hFF) ? 8'hFF : pulses_q + 8'd1;
            if (pulses_d == num_q) begin
              state_d = DONE;
            end else begin
              state_d = GAP;
              cnt_d   = len_m1(gap_q);
            end
          end else begin
            // DELAY or GAP expired
            state_d = GLITCH;
            cnt_d   = len_m1(wid_q);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tmr_q    <= '0;
      dly_q    <= '0;
      wid_q    <= '0;
      gap_q    <= '0;
      num_q    <= '0;
      trig_q   <= 1'b0;
      err_q    <= 1'b0;
      pulses_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      trig_q   <= trigger;
      err_q    <= err_d;
      pulses_q <= pulses_d;
      if (ld_cfg) begin
        dly_q <= cfg_delay;
        wid_q <= cfg_width;
        gap_q <= cfg_gap;
        num_q <= cfg_count;
      end
    end
  end

  assign glitch_en   = (state_q == GLITCH);
  assign pll_relock  = (state_q == RELOCK);
  assign done        = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign error       = err_q;
  assign pulses_done = pulses_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Scoreboard bench for glitch_sequencer: expected windows and done pulses are
// queued when stimulus is applied and matched as the DUT produces them.
module tb_glitch_sequencer;
  localparam int CNT_W = 16;
  localparam int RLK   = 16;
  localparam int TMO   = 100;

  logic             clk, reset;
  logic [CNT_W-1:0] cfg_delay, cfg_width, cfg_gap;
  logic [7:0]       cfg_count;
  logic             cfg_relock, start, abort, trigger, pll_locked;
  logic             pll_relock, glitch_en, busy, done, error;
  logic [7:0]       pulses_done;

  glitch_sequencer #(.CNT_W(CNT_W), .RELOCK_CYCLES(RLK), .LOCK_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_gap(cfg_gap),
    .cfg_count(cfg_count), .cfg_relock(cfg_relock),
    .start(start), .abort(abort), .trigger(trigger), .pll_locked(pll_locked),
    .pll_relock(pll_relock), .glitch_en(glitch_en), .busy(busy), .done(done),
    .error(error), .pulses_done(pulses_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc is the index of the edge just taken.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int s; int l; } win_t;
  typedef struct { int c; int p; } done_t;
  win_t  exp_q[$];
  done_t done_q[$];

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, cyc);
  endtask

  // Output monitor
  logic ge_prev = 1'b0;
  int   rise_c  = 0;
  always @(negedge clk) begin : mon
    win_t  w;
    done_t d;
    if (glitch_en && !ge_prev) rise_c = cyc;
    if (!glitch_en && ge_prev) begin
      if (exp_q.size() == 0) chk("win_unexp_len", cyc - rise_c, 0);
      else begin
        w = exp_q.pop_front();
        chk("win_start", rise_c, w.s);
        chk("win_len", cyc - rise_c, w.l);
      end
    end
    ge_prev = glitch_en;
    if (done) begin
      if (done_q.size() == 0) chk("done_unexp", 1, 0);
      else begin
        d = done_q.pop_front();
        chk("done_edge", cyc, d.c);
        chk("done_pulses", pulses_done, d.p);
      end
    end
  end

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_start(input int d, input int w, input int g, input int c,
                          input bit r, output int s);
    cfg_delay = CNT_W'(d); cfg_width = CNT_W'(w); cfg_gap = CNT_W'(g);
    cfg_count = 8'(c); cfg_relock = r;
    start = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_trig(output int n);
    trigger = 1'b1;
    n = cyc + 1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  // Queue the full run: windows and the done pulse, relative to trigger edge n.
  task automatic push_run(input int n, input int d, input int w, input int g, input int c);
    int ww, gg;
    win_t x;
    done_t y;
    ww = (w == 0) ? 1 : w;
    gg = (g == 0) ? 1 : g;
    for (int k = 0; k < c; k++) begin
      x.s = n + d + k * (ww + gg);
      x.l = ww;
      exp_q.push_back(x);
    end
    y.c = n + d + c * ww + (c - 1) * gg;
    y.p = c;
    done_q.push_back(y);
  endtask

  initial begin
    int s, n;
    int rl;
    win_t  x;
    done_t y;
    reset = 1'b1; cfg_delay = '0; cfg_width = '0; cfg_gap = '0; cfg_count = '0;
    cfg_relock = 1'b0; start = 1'b0; abort = 1'b0; trigger = 1'b0; pll_locked = 1'b1;
    nclk(2);
    chk("rst_glitch", glitch_en, 0);
    chk("rst_relock", pll_relock, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_pulses", pulses_done, 0);
    reset = 1'b0;
    nclk(2);

    // Basic 3-window run; cfg changed mid-run must be ignored
    do_start(3, 2, 4, 3, 0, s);
    cfg_delay = 16'd9; cfg_width = 16'd1; cfg_count = 8'd1;
    nclk(2);
    pulse_trig(n);
    push_run(n, 3, 2, 4, 3);
    wait_to(n + 19);
    chk("s1_busy_end", busy, 0);
    chk("s1_pulses", pulses_done, 3);
    chk("s1_error", error, 0);

    // count=0: done right after start, no glitch
    do_start(0, 0, 0, 0, 0, s);
    y.c = s; y.p = 0; done_q.push_back(y);
    nclk(3);
    chk("c0_busy", busy, 0);

    // zero delay / zero width single window
    do_start(0, 0, 0, 1, 0, s);
    nclk(2);
    pulse_trig(n);
    push_run(n, 0, 0, 0, 1);
    wait_to(n + 3);
    chk("d0_busy", busy, 0);

    // Relock then late lock
    pll_locked = 1'b0;
    do_start(1, 1, 1, 1, 1, s);
    rl = 0;
    while (pll_relock && rl < 40) begin rl++; @(negedge clk); end
    chk("relock_len", rl, RLK);
    nclk(4);
    chk("wl_busy", busy, 1);
    pll_locked = 1'b1;
    nclk(3);
    chk("armed_no_glitch", glitch_en, 0);
    chk("armed_busy", busy, 1);
    pulse_trig(n);
    push_run(n, 1, 1, 1, 1);
    wait_to(n + 4);
    chk("rl_busy_end", busy, 0);

    // Lock timeout after relock
    pll_locked = 1'b0;
    do_start(1, 1, 1, 1, 1, s);
    wait_to(s + RLK + TMO - 1);
    chk("tmo_busy_pre", busy, 1);
    chk("tmo_err_pre", error, 0);
    nclk(1);
    chk("tmo_busy", busy, 0);
    chk("tmo_err", error, 1);
    nclk(2);
    chk("tmo_err_sticky", error, 1);
    do_start(0, 0, 0, 0, 0, s);
    y.c = s; y.p = 0; done_q.push_back(y);
    chk("err_cleared", error, 0);
    pll_locked = 1'b1;
    nclk(2);

    // Abort in 4th cycle of second window
    do_start(2, 10, 2, 2, 0, s);
    nclk(2);
    pulse_trig(n);
    x.s = n + 2;      x.l = 10; exp_q.push_back(x);
    x.s = n + 2 + 12; x.l = 4;  exp_q.push_back(x);
    wait_to(n + 2 + 12 + 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abt_glitch", glitch_en, 0);
    chk("abt_busy", busy, 0);
    chk("abt_pulses", pulses_done, 1);
    chk("abt_error", error, 0);

    // start + abort together in IDLE: stays idle, nothing cleared
    cfg_count = 8'd0; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_pulses", pulses_done, 1);
    nclk(2);

    // Lock loss during DELAY
    do_start(10, 1, 1, 1, 0, s);
    nclk(2);
    pulse_trig(n);
    pll_locked = 1'b0;
    @(negedge clk);
    chk("ll_busy", busy, 0);
    chk("ll_error", error, 1);
    chk("ll_glitch", glitch_en, 0);
    pll_locked = 1'b1;
    nclk(12);

    // Async reset mid-GAP
    do_start(0, 2, 8, 3, 0, s);
    nclk(2);
    pulse_trig(n);
    x.s = n; x.l = 2; exp_q.push_back(x);
    wait_to(n + 4);
    chk("gap_busy", busy, 1);
    chk("gap_pulses", pulses_done, 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_glitch", glitch_en, 0);
    chk("ar_pulses", pulses_done, 0);
    chk("ar_done", done, 0);
    chk("ar_relock", pll_relock, 0);
    @(negedge clk);
    reset = 1'b0;
    nclk(15);

    chk("win_q_left", exp_q.size(), 0);
    chk("done_q_left", done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
